// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, the display word layout and the leading-zero
// helper used by the hex display scanner.
package disp_pkg;

    localparam int NDIG        = 4;
    localparam int NIB_W       = 4;
    localparam int IDX_W       = 2;
    localparam int HEX_W       = NDIG * NIB_W;
    localparam int DIV_DEFAULT = 50000;
    localparam int GAP_DEFAULT = 500;

    localparam logic [NDIG-1:0] AN_OFF = 4'b1111;

    // One complete display word: four nibbles, four decimal points, four blanks.
    typedef struct packed {
        logic [HEX_W-1:0] hex;
        logic [NDIG-1:0]  pt;
        logic [NDIG-1:0]  le;
    } disp_word_t;

    // True when digit idx is a leading zero: idx is not the rightmost digit
    // and every nibble from the leftmost digit down to idx is zero.
    function automatic logic leading_zero(input logic [HEX_W-1:0] hexWord,
                                          input logic [IDX_W-1:0] idx);
        logic allZero;
        allZero = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if ((d >= int'(idx)) && (hexWord[d*NIB_W +: NIB_W] != '0)) begin
                allZero = 1'b0;
            end
        end
        return allZero && (idx != '0);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: per-slot cycle counter for the display scanner. Reports the
// last cycle of each slot (wrap) and the trailing anti-ghosting window (blank).
module scan_tick_gen #(
    parameter int DIV = 4,
    parameter int GAP = 1,
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_wrap,
    output logic o_blank
);

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIV - 1);
    localparam logic [31:0]      ON_LEN = 32'(DIV - GAP);

    logic [CNT_W-1:0] r_cnt;

    // Slot counter: runs 0..DIV-1 and wraps back to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_wrap  = (r_cnt == LAST);
    assign o_blank = (32'(r_cnt) >= ON_LEN);

endmodule

// File: rtl/hex_disp_scanner.sv
// hex_disp_scanner: time-multiplexed scan driver for a 4-digit common-anode
// 7-segment display feeding an MC14495 decoder. New words are double-buffered
// and only swapped in at a frame boundary so the display never tears.
// Optional feature: define LZ_BLANK_EN for leading-zero blanking.
module hex_disp_scanner
    import disp_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT,
    parameter int GAP = GAP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [HEX_W-1:0]  hex_in,
    input  logic [NDIG-1:0]   pt_in,
    input  logic [NDIG-1:0]   le_in,
    output logic              upd_done,
    output logic              pend,
    output logic [NIB_W-1:0]  hex,
    output logic              point,
    output logic              LE,
    output logic [NDIG-1:0]   AN
);

    logic             w_wrap;
    logic             w_blank;
    logic             w_boundary;
    logic             w_leSel;
    disp_word_t       w_newWord;

    logic [IDX_W-1:0] r_idx;
    disp_word_t       r_pending;
    disp_word_t       r_shadow;
    logic             r_pend;
    logic             r_updDone;
    logic [NDIG-1:0]  r_an;
    logic [NIB_W-1:0] r_hex;
    logic             r_point;
    logic             r_le;

    scan_tick_gen #(
        .DIV (DIV),
        .GAP (GAP)
    ) u_tick (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_wrap  (w_wrap),
        .o_blank (w_blank)
    );

    assign w_boundary = w_wrap && (r_idx == IDX_W'(NDIG - 1));
    assign w_newWord  = {hex_in, pt_in, le_in};

`ifdef LZ_BLANK_EN
    assign w_leSel = r_shadow.le[r_idx] | leading_zero(r_shadow.hex, r_idx);
`else
    assign w_leSel = r_shadow.le[r_idx];
`endif

    // Digit index steps to the next digit whenever a slot ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_wrap) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Double buffer: frame boundary moves pending into shadow using the old
    // pending value; a load in the same cycle refills pending and keeps pend set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_shadow  <= '0;
            r_pend    <= 1'b0;
            r_updDone <= 1'b0;
        end else begin
            r_updDone <= 1'b0;
            if (w_boundary && r_pend) begin
                r_shadow  <= r_pending;
                r_pend    <= 1'b0;
                r_updDone <= 1'b1;
            end
            if (load) begin
                r_pending <= w_newWord;
                r_pend    <= 1'b1;
            end
        end
    end

    // Registered decoder/anode drive; during the gap the anodes are off and
    // the nibble and point simply hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an    <= AN_OFF;
            r_le    <= 1'b1;
            r_hex   <= '0;
            r_point <= 1'b0;
        end else if (w_blank) begin
            r_an    <= AN_OFF;
            r_le    <= 1'b1;
        end else begin
            r_an    <= ~(NDIG'(1) << r_idx);
            r_hex   <= r_shadow.hex[r_idx*NIB_W +: NIB_W];
            r_point <= r_shadow.pt[r_idx];
            r_le    <= w_leSel;
        end
    end

    assign upd_done = r_updDone;
    assign pend     = r_pend;
    assign hex      = r_hex;
    assign point    = r_point;
    assign LE       = r_le;
    assign AN       = r_an;

endmodule

// File: tb/tb_hex_disp_scanner.sv
// tb_hex_disp_scanner: self-checking bench for hex_disp_scanner with DIV=4,
// GAP=1. A cycle-count based reference model predicts every output.
module tb_hex_disp_scanner;

    localparam int DIV   = 4;
    localparam int GAP   = 1;
    localparam int NDIG  = 4;
    localparam int FRAME = NDIG * DIV;

    localparam logic [3:0] AN_ON [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] hex_in;
    logic [3:0]  pt_in;
    logic [3:0]  le_in;
    logic        upd_done;
    logic        pend;
    logic [3:0]  hex;
    logic        point;
    logic        LE;
    logic [3:0]  AN;

    int errors = 0;
    int checks = 0;

    int          mCyc;
    logic [15:0] mShHex, mPdHex;
    logic [3:0]  mShPt, mShLe, mPdPt, mPdLe;
    logic        mPend;
    logic        eUpd, ePend, ePoint, eLE;
    logic [3:0]  eHex, eAN;

    wire [11:0] obsVec = {upd_done, pend, hex, point, LE, AN};
    wire [11:0] expVec = {eUpd, ePend, eHex, ePoint, eLE, eAN};

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    hex_disp_scanner #(.DIV(DIV), .GAP(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .hex_in   (hex_in),
        .pt_in    (pt_in),
        .le_in    (le_in),
        .upd_done (upd_done),
        .pend     (pend),
        .hex      (hex),
        .point    (point),
        .LE       (LE),
        .AN       (AN)
    );

    function automatic logic lzBlank(input logic [15:0] h, input int d);
`ifdef LZ_BLANK_EN
        return (d != 0) && ((h >> (4 * d)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelReset();
        mCyc = 0;
        mShHex = '0; mShPt = '0; mShLe = '0;
        mPdHex = '0; mPdPt = '0; mPdLe = '0;
        mPend = 1'b0;
        eUpd = 1'b0; ePend = 1'b0; eHex = '0; ePoint = 1'b0; eLE = 1'b1; eAN = 4'b1111;
    endtask

    // Drive one cycle of inputs and advance the model across the clock edge.
    task automatic step(input logic ld, input logic [15:0] h, input logic [3:0] p,
                        input logic [3:0] l);
        int phase;
        int digit;
        load = ld; hex_in = h; pt_in = p; le_in = l;
        @(posedge clk);
        phase = mCyc % DIV;
        digit = (mCyc / DIV) % NDIG;
        if (phase < DIV - GAP) begin
            eAN    = AN_ON[digit];
            eHex   = 4'((mShHex >> (4 * digit)) & 16'hF);
            ePoint = mShPt[digit];
            eLE    = mShLe[digit] | lzBlank(mShHex, digit);
        end else begin
            eAN = 4'b1111;
            eLE = 1'b1;
        end
        eUpd = (phase == DIV - 1) && (digit == NDIG - 1) && mPend;
        if (eUpd) begin
            mShHex = mPdHex; mShPt = mPdPt; mShLe = mPdLe;
            mPend = 1'b0;
        end
        if (ld) begin
            mPdHex = h; mPdPt = p; mPdLe = l;
            mPend = 1'b1;
        end
        ePend = mPend;
        mCyc++;
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (AN !== 4'b1111) begin errors++; $display("[TB] FAIL reset_an: got %b expected 1111", AN); end
        checks++;
        if (LE !== 1'b1) begin errors++; $display("[TB] FAIL reset_le: got %b expected 1", LE); end
        checks++;
        if ({hex, point, pend, upd_done} !== 7'b0) begin
            errors++; $display("[TB] FAIL reset_misc: got %b expected 0000000", {hex, point, pend, upd_done});
        end
        #4 rst_n = 1'b1;
        step(1'b0, '0, '0, '0);
        checks++;
        if ({AN, LE, hex} !== {4'b1110, 1'b0, 4'h0}) begin
            errors++; $display("[TB] FAIL reset_first_slot: got %b expected 111000000", {AN, LE, hex});
        end
        for (int n = 1; n < FRAME; n++) begin
            step(1'b0, '0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL reset_model cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
        end
    endtask

    task automatic test_basic_frame();
        logic [3:0] sHex [4];
        logic       sPt [4];
        bit         found;
        sHex = '{4'h4, 4'h3, 4'h2, 4'h1};
        sPt  = '{1'b0, 1'b0, 1'b1, 1'b0};
        step(1'b1, 16'h1234, 4'b0100, 4'b0000);
        checks++;
        if (obsVec !== expVec) begin errors++; $display("[TB] FAIL basic_load cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
        found = 1'b0;
        for (int n = 0; n < 2 * FRAME && !found; n++) begin
            step(1'b0, '0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL basic_model cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
            found = (upd_done === 1'b1);
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL basic_upd_timeout: got 0 expected 1"); end
        for (int s = 0; s < NDIG; s++) begin
            for (int c = 0; c < DIV; c++) begin
                step(1'b0, '0, '0, '0);
                checks++;
                if (c < DIV - GAP) begin
                    if ({AN, LE, hex, point} !== {AN_ON[s], 1'b0, sHex[s], sPt[s]}) begin
                        errors++; $display("[TB] FAIL basic_slot%0d_on: got %b expected %b", s, {AN, LE, hex, point}, {AN_ON[s], 1'b0, sHex[s], sPt[s]});
                    end
                end else if ({AN, LE, hex, point} !== {4'b1111, 1'b1, sHex[s], sPt[s]}) begin
                    errors++; $display("[TB] FAIL basic_slot%0d_gap: got %b expected %b", s, {AN, LE, hex, point}, {4'b1111, 1'b1, sHex[s], sPt[s]});
                end
            end
        end
    endtask

    task automatic test_overwrite();
        int updCount;
        bit sawA;
        for (int n = 0; n < FRAME && (mCyc % FRAME) != 0; n++) begin
            step(1'b0, '0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL ovr_align cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
        end
        step(1'b1, 16'hAAAA, 4'b1111, 4'b0000);
        checks++;
        if (obsVec !== expVec) begin errors++; $display("[TB] FAIL ovr_first cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
        for (int n = 0; n < 3; n++) begin
            step(1'b0, '0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL ovr_gap cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
        end
        step(1'b1, 16'hBEEF, 4'b0001, 4'b0000);
        checks++;
        if (obsVec !== expVec) begin errors++; $display("[TB] FAIL ovr_second cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
        updCount = 0;
        sawA = 1'b0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            step(1'b0, '0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL ovr_model cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
            if (upd_done === 1'b1) updCount++;
            if (AN !== 4'b1111 && hex === 4'hA) sawA = 1'b1;
        end
        checks++;
        if (updCount != 1) begin errors++; $display("[TB] FAIL ovr_upd_count: got %0d expected 1", updCount); end
        checks++;
        if (sawA) begin errors++; $display("[TB] FAIL ovr_stale_word: got AAAA shown expected BEEF only"); end
    endtask

    task automatic test_boundary_load();
        for (int n = 0; n < FRAME && (mCyc % FRAME) != 0; n++) begin
            step(1'b0, '0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL bnd_align cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
        end
        step(1'b1, 16'h1234, 4'b0000, 4'b0000);
        for (int n = 0; n < FRAME && (mCyc % FRAME) != FRAME - 1; n++) begin
            step(1'b0, '0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL bnd_wait cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
        end
        step(1'b1, 16'h5555, 4'b1010, 4'b0000);
        checks++;
        if ({upd_done, pend} !== 2'b11) begin errors++; $display("[TB] FAIL bnd_edge: got %b expected 11", {upd_done, pend}); end
        for (int n = 0; n < FRAME; n++) begin
            step(1'b0, '0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL bnd_model cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
            if (n == 0) begin
                checks++;
                if ({AN, hex} !== {4'b1110, 4'h4}) begin errors++; $display("[TB] FAIL bnd_old_word: got %b expected 11100100", {AN, hex}); end
            end
            if (n < FRAME - 1) begin
                checks++;
                if (pend !== 1'b1) begin errors++; $display("[TB] FAIL bnd_pend_hold n=%0d: got %b expected 1", n, pend); end
            end
        end
        checks++;
        if ({upd_done, pend} !== 2'b10) begin errors++; $display("[TB] FAIL bnd_second_upd: got %b expected 10", {upd_done, pend}); end
        step(1'b0, '0, '0, '0);
        checks++;
        if ({AN, hex} !== {4'b1110, 4'h5}) begin errors++; $display("[TB] FAIL bnd_new_word: got %b expected 11100101", {AN, hex}); end
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < FRAME && (mCyc % FRAME) != 0; n++) begin
            step(1'b0, '0, '0, '0);
        end
        step(1'b1, 16'hC3A5, 4'b0110, 4'b0000);
        for (int n = 0; n < FRAME && (mCyc % FRAME) != 9; n++) begin
            step(1'b0, '0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL arst_pre cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
        end
        checks++;
        if (AN !== 4'b1011) begin errors++; $display("[TB] FAIL arst_pre_an: got %b expected 1011", AN); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({AN, LE, pend, upd_done, hex, point} !== {4'b1111, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            errors++; $display("[TB] FAIL arst_immediate: got %b expected 11111000000", {AN, LE, pend, upd_done, hex, point});
        end
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #4 rst_n = 1'b1;
        step(1'b0, '0, '0, '0);
        checks++;
        if ({AN, LE, hex, point} !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
            errors++; $display("[TB] FAIL arst_restart: got %b expected 1110000000", {AN, LE, hex, point});
        end
        for (int n = 1; n < 2 * FRAME; n++) begin
            step(1'b0, '0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL arst_model cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
        end
    endtask

    task automatic test_lz();
        logic [3:0] sHex [4];
        logic       sLe [4];
        bit         found;
        sHex = '{4'h0, 4'h7, 4'h0, 4'h0};
`ifdef LZ_BLANK_EN
        sLe = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        sLe = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        step(1'b1, 16'h0070, 4'b0000, 4'b0000);
        found = 1'b0;
        for (int n = 0; n < 2 * FRAME && !found; n++) begin
            step(1'b0, '0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL lz_model cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
            found = (upd_done === 1'b1);
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL lz_upd_timeout: got 0 expected 1"); end
        for (int s = 0; s < NDIG; s++) begin
            for (int c = 0; c < DIV; c++) begin
                step(1'b0, '0, '0, '0);
                if (c < DIV - GAP) begin
                    checks++;
                    if ({AN, hex, LE} !== {AN_ON[s], sHex[s], sLe[s]}) begin
                        errors++; $display("[TB] FAIL lz_slot%0d: got %b expected %b", s, {AN, hex, LE}, {AN_ON[s], sHex[s], sLe[s]});
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] hv;
        for (int n = 0; n < 12 * FRAME; n++) begin
            if ($urandom_range(7, 0) == 0) begin
                hv = 16'($urandom);
                if ($urandom_range(1, 0) == 1) hv = hv >> (4 * $urandom_range(3, 0));
                step(1'b1, hv, 4'($urandom), 4'($urandom));
            end else begin
                step(1'b0, '0, '0, '0);
            end
            checks++;
            if (obsVec !== expVec) begin errors++; $display("[TB] FAIL random_model cyc=%0d: got %h expected %h", mCyc, obsVec, expVec); end
        end
    endtask

    // Test sequence and summary.
    initial begin
        rst_n = 1'b0; load = 1'b0; hex_in = '0; pt_in = '0; le_in = '0;
        modelReset();
        test_reset();
        test_basic_frame();
        test_overwrite();
        test_boundary_load();
        test_async_reset();
        test_lz();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
